// File: rtl/arm_motion_seq.sv
// Pose sequencer for the servo arm: walks a writable pose table and slews the two joint
// set-points toward each pose once per servo frame, then applies the gripper and dwells.
module arm_motion_seq #(
  // The 50 MHz default widths need W >= 17 to be represented; override W accordingly.
  parameter int W            = 16,
  parameter int AW           = 3,
  parameter int FRAME_CYCLES = 1000000,
  parameter int STEP         = 500,
  parameter int INIT_W       = 75000,
  parameter int MIN_W        = 25000,
  parameter int MAX_W        = 125000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tbl_we,
  input  logic [AW-1:0]   tbl_addr,
  input  logic [2*W+8:0]  tbl_wdata,
  input  logic [AW-1:0]   last_pose,
  input  logic            loop,
  input  logic            start,
  input  logic            stop,
  output logic [W-1:0]    s1_width,
  output logic [W-1:0]    s2_width,
  output logic            grip_close,
  output logic            frame_tick,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   cur_pose
);

  localparam int FCW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_CYCLES - 1);
  localparam logic [W-1:0] INIT_V = W'(INIT_W);
  localparam logic [W-1:0] MIN_V  = W'(MIN_W);
  localparam logic [W-1:0] MAX_V  = W'(MAX_W);
  localparam logic [W-1:0] STEP_V = W'(STEP);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] RAMP  = 2'd2;
  localparam logic [1:0] DWELL = 2'd3;

  logic [1:0]     state;
  logic [FCW-1:0] frame_cnt;
  logic [2*W+8:0] tbl [2**AW];
  logic [2*W+8:0] ent;
  logic [W-1:0]   tgt1, tgt2;
  logic           grip_t;
  logic [7:0]     dwell_t, dwell_cnt;
  logic           at_target;

  function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
    if (v < MIN_V) return MIN_V;
    if (v > MAX_V) return MAX_V;
    return v;
  endfunction

  // Direction is chosen first so the difference is always non-negative.
  function automatic logic [W-1:0] step_to(input logic [W-1:0] cur, input logic [W-1:0] tgt);
    logic [W-1:0] diff;
    // NOTE: blocking assignments are correct here: this is combinational scratch inside a function.
    if (cur < tgt) begin
      diff = tgt - cur;
      return cur + ((diff > STEP_V) ? STEP_V : diff);
    end
    diff = cur - tgt;
    return cur - ((diff > STEP_V) ? STEP_V : diff);
  endfunction

  assign frame_tick = (frame_cnt == FRAME_LAST);
  assign ent        = tbl[cur_pose];
  assign at_target  = (s1_width == tgt1) && (s2_width == tgt2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= '0;
    else                 frame_cnt <= frame_cnt + 1'b1;
  end

  // NOTE: the pose table is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl[tbl_addr] <= tbl_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      s1_width   <= INIT_V;
      s2_width   <= INIT_V;
      grip_close <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cur_pose   <= '0;
      tgt1       <= INIT_V;
      tgt2       <= INIT_V;
      grip_t     <= 1'b0;
      dwell_t    <= '0;
      dwell_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (stop && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start && !stop) begin
            cur_pose <= '0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
          LOAD: begin
            tgt1    <= clamp(ent[W-1:0]);
            tgt2    <= clamp(ent[2*W-1:W]);
            dwell_t <= ent[2*W+7:2*W];
            grip_t  <= ent[2*W+8];
            state   <= RAMP;
          end
          RAMP: begin
            if (at_target) begin
              grip_close <= grip_t;
              dwell_cnt  <= dwell_t;
              state      <= DWELL;
            end else if (frame_tick) begin
              s1_width <= step_to(s1_width, tgt1);
              s2_width <= step_to(s2_width, tgt2);
            end
          end
          DWELL: begin
            if (dwell_cnt == '0) begin
              if (cur_pose != last_pose) begin
                cur_pose <= cur_pose + 1'b1;
                state    <= LOAD;
              end else if (loop) begin
                cur_pose <= '0;
                state    <= LOAD;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else if (frame_tick) begin
              dwell_cnt <= dwell_cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
